// File: rtl/prefix_adder_pkg.sv
// Shared constants and state encoding for the multi-precision add sequencer.
package prefix_adder_pkg;

  // Width of one datapath word handled by the prefix adder per cycle.
  localparam int unsigned ADDER_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle    = ST_IDLE,
    StRun     = ST_RUN,
    StDone    = ST_DONE,
    StIllegal = 2'd3
  } seq_state_e;

  // The unused encoding behaves exactly like IDLE.
  function automatic seq_state_e decode_state(input seq_state_e s);
    return (s == StIllegal) ? StIdle : s;
  endfunction

endpackage

// File: rtl/mp_add_sequencer_sklansky.sv
// 16-bit Sklansky parallel-prefix adder with carry-in and carry-out.
module mp_add_sequencer_sklansky
  import prefix_adder_pkg::*;
(
  input  logic [ADDER_W-1:0] a,
  input  logic [ADDER_W-1:0] b,
  input  logic               cin,
  output logic [ADDER_W-1:0] sum,
  output logic               cout
);

  localparam int unsigned Lvl = $clog2(ADDER_W);

  // Group generate/propagate per prefix level; level 0 is the bitwise pair.
  logic [Lvl:0][ADDER_W-1:0] g;
  logic [Lvl:0][ADDER_W-1:0] p;
  logic [ADDER_W-1:0]        c;

  assign g[0] = a & b;
  assign p[0] = a ^ b;

  for (genvar l = 0; l < Lvl; l++) begin : g_level
    for (genvar i = 0; i < ADDER_W; i++) begin : g_bit
      if (((i >> l) & 1) == 1) begin : g_comb
        // Combine with the last bit of the lower half of this 2^(l+1) block.
        localparam int J = ((i >> l) << l) - 1;
        assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][J]);
        assign p[l+1][i] = p[l][i] & p[l][J];
      end else begin : g_pass
        assign g[l+1][i] = g[l][i];
        assign p[l+1][i] = p[l][i];
      end
    end
  end

  assign c[0] = cin;
  for (genvar i = 1; i < ADDER_W; i++) begin : g_carry
    assign c[i] = g[Lvl][i-1] | (p[Lvl][i-1] & cin);
  end

  assign sum  = p[0] ^ c;
  assign cout = g[Lvl][ADDER_W-1] | (p[Lvl][ADDER_W-1] & cin);

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: runs a WORDS*16-bit operand pair through
// one 16-bit prefix adder, one word per cycle LSW first, rippling carry between words.
module mp_add_sequencer
  import prefix_adder_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORDS*ADDER_W-1:0]   a,
  input  logic [WORDS*ADDER_W-1:0]   b,
  input  logic                       cin,
  input  logic                       sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORDS*ADDER_W-1:0]   sum,
  output logic                       cout,
  output logic                       ovf,
  output logic                       busy
);

  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;

  seq_state_e state_q, state_d, state_dec;
  logic [IdxW-1:0] idx_q, idx_d;
  logic carry_q, carry_d;
  logic [WORDS-1:0][ADDER_W-1:0] a_q, a_d;
  logic [WORDS-1:0][ADDER_W-1:0] b_q, b_d;   // already inverted for subtract
  logic [WORDS-1:0][ADDER_W-1:0] sum_q, sum_d;
  logic cout_q, cout_d;
  logic ovf_q, ovf_d;

  logic [ADDER_W-1:0] add_a, add_b, add_sum;
  logic               add_cout;
  logic               last_word;

  assign add_a     = a_q[idx_q];
  assign add_b     = b_q[idx_q];
  assign last_word = (idx_q == IdxW'(WORDS - 1));

  mp_add_sequencer_sklansky u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_dec = decode_state(state_q);
    state_d   = state_dec;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    case (state_dec)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[idx_q] = add_sum;
        carry_d      = add_cout;
        idx_d        = idx_q + IdxW'(1);
        if (last_word) begin
          cout_d  = add_cout;
          // Signed overflow: operands agree in sign but the result does not.
          ovf_d   = (a_q[WORDS-1][ADDER_W-1] == b_q[WORDS-1][ADDER_W-1]) &&
                    (add_sum[ADDER_W-1] != a_q[WORDS-1][ADDER_W-1]);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counter, carry, operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake and status outputs; in_ready is held low for the whole reset.
  always_comb begin
    in_ready  = !rst && (decode_state(state_q) == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q == StRun) || (state_q == StDone);
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Self-checking bench for mp_add_sequencer (WORDS=4) with a transaction-level model.
module tb_mp_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = WORDS * 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  mp_add_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-operation reference: {ovf, cout, sum} from plain wide arithmetic.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                          input logic rcin, input logic rsub);
    logic [W-1:0] be;
    logic [W:0]   full;
    logic         c;
    logic         o;
    be   = rsub ? ~rb : rb;
    c    = rsub ? 1'b1 : rcin;
    full = {1'b0, ra} + {1'b0, be} + {{W{1'b0}}, c};
    o    = (ra[W-1] == be[W-1]) && (full[W-1] != ra[W-1]);
    return {o, full[W], full[W-1:0]};
  endfunction

  // Model: a pending operation completes WORDS edges after acceptance and is held until taken.
  bit           m_init = 0;
  bit           m_busy = 0;
  bit           m_valid = 0;
  bit           m_sum_known = 0;
  int           m_cnt = 0;
  int           m_done = 0;
  logic [W+1:0] m_res = '0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_busy = 0; m_valid = 0; m_sum_known = 1;
      m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (m_init) begin
      if (m_valid) begin
        if (out_ready) begin
          m_valid = 0;
          m_done++;
        end
      end else if (m_busy) begin
        m_cnt++;
        if (m_cnt == WORDS) begin
          m_busy = 0; m_valid = 1; m_sum_known = 1;
          {m_ovf, m_cout, m_sum} = m_res;
        end
      end else if (in_valid) begin
        m_res = ref_op(a, b, cin, sub);
        m_busy = 1; m_cnt = 0; m_sum_known = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", in_ready, !rst && !m_busy && !m_valid);
      chk("out_valid", out_valid, m_valid);
      chk("busy", busy, m_busy || m_valid);
      chk("cout", cout, m_cout);
      chk("ovf", ovf, m_ovf);
      if (m_sum_known) chk("sum", sum, m_sum);
    end
  end

  // Issue one pair; called and returns at posedge+2.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic icin, input logic isub);
    a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("accepted", busy, 1'b1);
    #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = $urandom; sub = $urandom;
  endtask

  // Wait for out_valid, returning the number of edges since the handshake.
  task automatic wait_result(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 40);
    if (!out_valid) chk("result_timeout", out_valid, 1'b1);
    #1;
  endtask

  task automatic expect_result(input string name, input logic [W-1:0] es,
                               input logic ec, input logic eo);
    chk({name, "_sum"}, sum, es);
    chk({name, "_cout"}, cout, ec);
    chk({name, "_ovf"}, ovf, eo);
    chk({name, "_model"}, m_sum, es);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("taken_idle", in_ready, 1'b1);
    #1;
    out_ready = 1'b0;
  endtask

  int n;

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;

    // Carry through all words, latency check.
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    wait_result(n);
    chk("latency", n, WORDS);
    expect_result("wrap", 64'h0, 1'b1, 1'b0);
    take_result();

    // Reset mid-idle with a nonzero previous result (cout=1).
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sum", sum, 64'h0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1'b1);
    @(posedge clk); #2;

    issue(64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 1'b0);
    wait_result(n);
    expect_result("word_carry", 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    take_result();

    issue(64'h5, 64'h7, 1'b1, 1'b1);
    wait_result(n);
    expect_result("sub_neg", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    take_result();

    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    wait_result(n);
    expect_result("ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // Hold the result while upstream keeps offering a new pair.
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; a = {$urandom, $urandom}; b = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("hold_ready", in_ready, 1'b0);
      chk("hold_sum", sum, 64'h8000_0000_0000_0000);
      chk("hold_valid", out_valid, 1'b1);
      #1;
    end
    in_valid = 1'b0;
    take_result();

    // Reset while idx==2 in RUN.
    issue(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_sum", sum, 64'h0);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort_no_result", out_valid, 1'b0);
    end
    #1;
    issue(64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1);
    wait_result(n);
    expect_result("after_abort", 64'h0000_0000_0000_0001, 1'b1, 1'b0);
    take_result();

    // Random traffic, including rare resets, checked cycle by cycle against the model.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #2;
      in_valid  = ($urandom_range(0, 2) != 0);
      a         = {$urandom, $urandom};
      b         = ($urandom_range(0, 3) == 0) ? ~a : {$urandom, $urandom};
      cin       = $urandom;
      sub       = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #2;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (WORDS + 4) @(posedge clk);
    #1;
    chk("drained", busy, 1'b0);
    chk("random_ops_done", m_done > 50, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
